// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified-memory arbiter: bus widths and response owner encoding.
package mem_arb_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int WMASK_W = 4;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and SRAM signals of the arbiter; the arbiter takes the slave view,
// the requesters plus SRAM take the master view.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic               inst_req;
   logic [ADDR_W-1:0]  inst_addr;
   logic               inst_addr_ok;
   logic               inst_data_ok;
   logic [DATA_W-1:0]  inst_rdata;

   logic               data_req;
   logic               data_wr;
   logic [WMASK_W-1:0] data_wmask;
   logic [ADDR_W-1:0]  data_addr;
   logic [DATA_W-1:0]  data_wdata;
   logic               data_addr_ok;
   logic               data_data_ok;
   logic [DATA_W-1:0]  data_rdata;

   logic               sram_en;
   logic [WMASK_W-1:0] sram_wen;
   logic [ADDR_W-1:0]  sram_addr;
   logic [DATA_W-1:0]  sram_wdata;
   logic [DATA_W-1:0]  sram_rdata;

   modport slave (
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_wmask, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output sram_en, sram_wen, sram_addr, sram_wdata,
      input  sram_rdata
   );

   modport master (
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_wmask, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  sram_en, sram_wen, sram_addr, sram_wdata,
      output sram_rdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant policy: data has fixed priority unless fetch has been starved long enough.
module mem_arb_pick (
   input  logic inst_req,
   input  logic data_req,
   input  logic starved,
   output logic gnt_inst,
   output logic gnt_data
);

   assign gnt_data = data_req && !(inst_req && starved);
   assign gnt_inst = inst_req && !gnt_data;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read SRAM between instruction fetch and data access, one access
// per cycle, with the response routed back to its owner one cycle after the grant.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int MAX_STARVE = 4,
   localparam int CNT_W      = $clog2(MAX_STARVE + 1)
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(MAX_STARVE);

   logic             inst_req_g;
   logic             data_req_g;
   logic             gnt_inst;
   logic             gnt_data;
   logic             starved;
   logic [CNT_W-1:0] wait_cnt;
   logic             resp_vld;
   logic             resp_own;

   // Requests are masked while reset is held so nothing reaches the SRAM.
   assign inst_req_g = bus.inst_req && reset;
   assign data_req_g = bus.data_req && reset;
   assign starved    = (wait_cnt == STARVE_LIMIT);

   mem_arb_pick u_pick (
      .inst_req (inst_req_g),
      .data_req (data_req_g),
      .starved  (starved),
      .gnt_inst (gnt_inst),
      .gnt_data (gnt_data)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (gnt_inst || !bus.inst_req) begin
         wait_cnt <= '0;
      end else if (gnt_data && (wait_cnt != STARVE_LIMIT)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp_vld <= 1'b0;
         resp_own <= OWN_INST;
      end else begin
         resp_vld <= gnt_inst || gnt_data;
         resp_own <= gnt_data ? OWN_DATA : OWN_INST;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;
      bus.sram_wen   = '0;
      if (gnt_data) begin
         bus.sram_addr  = bus.data_addr;
         bus.sram_wdata = bus.data_wdata;
         if (bus.data_wr) begin
            bus.sram_wen = bus.data_wmask;
         end
      end else if (gnt_inst) begin
         bus.sram_addr = bus.inst_addr;
      end
   end

   assign bus.sram_en      = gnt_inst || gnt_data;
   assign bus.inst_addr_ok = gnt_inst;
   assign bus.data_addr_ok = gnt_data;

   assign bus.inst_data_ok = resp_vld && (resp_own == OWN_INST);
   assign bus.data_data_ok = resp_vld && (resp_own == OWN_DATA);
   assign bus.inst_rdata   = bus.sram_rdata;
   assign bus.data_rdata   = bus.sram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: SRAM model, reference memory and a response scoreboard.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   cyc;

   mem_arbiter_if bus ();

   mem_arbiter #(.MAX_STARVE(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic        own;
      logic [31:0] data;
      logic        chk_data;
      int          cyc;
   } resp_t;

   resp_t       sb[$];
   logic [31:0] sram_mem [logic [29:0]];
   logic [31:0] ref_mem  [logic [29:0]];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] word);
      sram_mem[addr[31:2]] = word;
      ref_mem[addr[31:2]]  = word;
   endtask

   // SRAM model: synchronous read, byte-masked write.
   always @(posedge clk) begin
      if (bus.sram_en) begin
         logic [31:0] w;
         w = sram_mem.exists(bus.sram_addr[31:2]) ? sram_mem[bus.sram_addr[31:2]] : 32'h0;
         bus.sram_rdata <= w;
         for (int b = 0; b < 4; b++) begin
            if (bus.sram_wen[b]) w[8*b +: 8] = bus.sram_wdata[8*b +: 8];
         end
         sram_mem[bus.sram_addr[31:2]] = w;
      end
   end

   // Response monitor: each data_ok must match the oldest outstanding grant.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.inst_data_ok || bus.data_data_ok) begin
            if (sb.size() == 0) begin
               check("ok_without_grant", {30'b0, bus.data_data_ok, bus.inst_data_ok}, 32'h0);
            end else begin
               resp_t e;
               e = sb.pop_front();
               check("resp_latency", cyc, e.cyc + 1);
               check("resp_owner", {30'b0, bus.data_data_ok, bus.inst_data_ok},
                     e.own ? 32'h2 : 32'h1);
               if (e.chk_data) begin
                  check(e.own ? "data_rdata" : "inst_rdata",
                        e.own ? bus.data_rdata : bus.inst_rdata, e.data);
               end
            end
         end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            resp_t e;
            e = sb.pop_front();
            check("missing_resp", {30'b0, bus.data_data_ok, bus.inst_data_ok},
                  e.own ? 32'h2 : 32'h1);
         end
      end
   end

   task automatic set_inst(input logic req, input logic [31:0] addr);
      bus.inst_req  = req;
      bus.inst_addr = addr;
   endtask

   task automatic set_data(input logic req, input logic wr, input logic [3:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bus.data_req   = req;
      bus.data_wr    = wr;
      bus.data_wmask = mask;
      bus.data_addr  = addr;
      bus.data_wdata = wdata;
   endtask

   // One cycle with the current inputs: check the grant and SRAM drive, push expected responses.
   task automatic step(input string tag, input logic exp_gi, input logic exp_gd);
      logic [31:0] exp_addr;
      logic [3:0]  exp_wen;
      @(negedge clk);
      exp_addr = exp_gd ? bus.data_addr : (exp_gi ? bus.inst_addr : 32'h0);
      exp_wen  = (exp_gd && bus.data_wr) ? bus.data_wmask : 4'b0000;
      check({tag, "_inst_addr_ok"}, bus.inst_addr_ok, exp_gi);
      check({tag, "_data_addr_ok"}, bus.data_addr_ok, exp_gd);
      check({tag, "_sram_en"}, bus.sram_en, exp_gi | exp_gd);
      check({tag, "_sram_addr"}, bus.sram_addr, exp_addr);
      check({tag, "_sram_wen"}, bus.sram_wen, exp_wen);
      if (exp_gi) begin
         sb.push_back('{OWN_INST, ref_mem[bus.inst_addr[31:2]], 1'b1, cyc});
      end
      if (exp_gd) begin
         if (bus.data_wr) begin
            logic [31:0] w;
            check({tag, "_sram_wdata"}, bus.sram_wdata, bus.data_wdata);
            w = ref_mem[bus.data_addr[31:2]];
            for (int b = 0; b < 4; b++) begin
               if (bus.data_wmask[b]) w[8*b +: 8] = bus.data_wdata[8*b +: 8];
            end
            ref_mem[bus.data_addr[31:2]] = w;
            sb.push_back('{OWN_DATA, 32'h0, 1'b0, cyc});
         end else begin
            sb.push_back('{OWN_DATA, ref_mem[bus.data_addr[31:2]], 1'b1, cyc});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b0;
      bus.sram_rdata = 32'h0;
      set_inst(1'b0, 32'h0);
      set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      preload(32'h1C00_0000, 32'h0010_0093);
      preload(32'h1C00_0004, 32'h0020_0113);
      preload(32'h1C00_0008, 32'h0030_8193);
      preload(32'h0000_0100, 32'h1122_3344);
      preload(32'h0000_0200, 32'hCAFE_F00D);
      preload(32'h0000_0204, 32'h0BAD_BEEF);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_inst_addr_ok", bus.inst_addr_ok, 1'b0);
      check("rst_data_addr_ok", bus.data_addr_ok, 1'b0);
      check("rst_inst_data_ok", bus.inst_data_ok, 1'b0);
      check("rst_data_data_ok", bus.data_data_ok, 1'b0);
      check("rst_sram_en", bus.sram_en, 1'b0);
      check("rst_sram_wen", bus.sram_wen, 4'b0000);
      check("rst_sram_addr", bus.sram_addr, 32'h0);
      check("rst_sram_wdata", bus.sram_wdata, 32'h0);
      check("rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Lone fetch
      set_inst(1'b1, 32'h1C00_0000);
      step("fetch", 1'b1, 1'b0);
      set_inst(1'b0, 32'h0);
      step("fetch_idle", 1'b0, 1'b0);

      // Lone store then load of the same word
      set_data(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hAABB_CCDD);
      step("store", 1'b0, 1'b1);
      set_data(1'b1, 1'b0, 4'b0000, 32'h0000_0100, 32'h0);
      step("load", 1'b0, 1'b1);
      set_data(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      step("load_idle", 1'b0, 1'b0);
      check("merged_word", ref_mem[30'h40], 32'h1122_CCDD);

      // Continuous conflict: data four times, then fetch, repeating
      set_inst(1'b1, 32'h1C00_0000);
      set_data(1'b1, 1'b0, 4'b0000, 32'h0000_0200, 32'h0);
      for (int i = 0; i < 10; i++) begin
         step("conflict", (i == 4 || i == 9), !(i == 4 || i == 9));
         if (i == 3) check("starve_cnt_full", 32'(dut.wait_cnt), 32'd4);
         if (i == 4) check("starve_cnt_clear", 32'(dut.wait_cnt), 32'd0);
      end
      set_inst(1'b0, 32'h0);
      set_data(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      step("conflict_idle", 1'b0, 1'b0);

      // Alternating back-to-back grants
      set_inst(1'b1, 32'h1C00_0004);
      step("alt_i0", 1'b1, 1'b0);
      set_inst(1'b0, 32'h0);
      set_data(1'b1, 1'b0, 4'b0000, 32'h0000_0204, 32'h0);
      step("alt_d", 1'b0, 1'b1);
      set_data(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      set_inst(1'b1, 32'h1C00_0008);
      step("alt_i1", 1'b1, 1'b0);
      set_inst(1'b0, 32'h0);
      step("alt_idle", 1'b0, 1'b0);

      // Reset in the cycle a load response is due
      set_data(1'b1, 1'b0, 4'b0000, 32'h0000_0200, 32'h0);
      step("rst_load", 1'b0, 1'b1);
      reset = 1'b0;
      sb.delete();
      set_inst(1'b1, 32'h1C00_0000);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_data_data_ok", bus.data_data_ok, 1'b0);
         check("midrst_inst_data_ok", bus.inst_data_ok, 1'b0);
         check("midrst_addr_ok", {30'b0, bus.data_addr_ok, bus.inst_addr_ok}, 32'h0);
         check("midrst_sram_en", bus.sram_en, 1'b0);
         check("midrst_sram_wen", bus.sram_wen, 4'b0000);
         check("midrst_wait_cnt", 32'(dut.wait_cnt), 32'h0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      step("post_rst_d", 1'b0, 1'b1);
      set_data(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
      step("post_rst_i", 1'b1, 1'b0);
      set_inst(1'b0, 32'h0);
      step("final_idle0", 1'b0, 1'b0);
      step("final_idle1", 1'b0, 1'b0);

      check("sb_empty", sb.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
